// File: rtl/mem_wb_skid.sv
// rtl/mem_wb_skid.sv - MEM/WB boundary with 2-entry skid buffer, flush, WB data select and stall counter
// Main register drives the WB side; skid register absorbs one entry so in_ready is purely registered.
module mem_wb_skid #(
  parameter int N          = 32,
  parameter int REGW       = 5,
  parameter int WBW        = 2,
  parameter int ZERO_GUARD = 1,
  parameter int CNTW       = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WBW-1:0]  WB_in,
  input  logic [REGW-1:0] loadreg,
  input  logic [N-1:0]    readdata,
  input  logic [N-1:0]    Aluresult,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WBW-1:0]  WB_out,
  output logic [REGW-1:0] loadout,
  output logic [N-1:0]    dataout,
  output logic [N-1:0]    Aluresout,
  output logic [N-1:0]    wb_data,
  output logic            wb_we,
  output logic [CNTW-1:0] stall_cnt
);

  localparam int PW = WBW + REGW + 2 * N;

  logic [PW-1:0]   in_pay;
  logic [PW-1:0]   m_pay_q, m_pay_d;
  logic [PW-1:0]   s_pay_q, s_pay_d;
  logic            m_valid_q, m_valid_d;
  logic            s_valid_q, s_valid_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic            acc, con;

  assign in_pay   = {WB_in, loadreg, readdata, Aluresult};
  assign in_ready = !s_valid_q;
  assign acc      = in_valid & in_ready;
  assign con      = m_valid_q & out_ready;

  always_comb begin
    m_pay_d     = m_pay_q;
    s_pay_d     = s_pay_q;
    m_valid_d   = m_valid_q;
    s_valid_d   = s_valid_q;
    stall_cnt_d = stall_cnt_q;

    if (m_valid_q && !out_ready && (stall_cnt_q != {CNTW{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNTW'(1);

    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q) begin
      // skid can never be occupied while main is empty
      if (acc) begin
        m_pay_d   = in_pay;
        m_valid_d = 1'b1;
      end
    end else if (con) begin
      if (s_valid_q) begin
        m_pay_d   = s_pay_q;
        s_valid_d = 1'b0;
      end else if (acc) begin
        m_pay_d = in_pay;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (acc) begin
      s_pay_d   = in_pay;
      s_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pay_q     <= '0;
      s_pay_q     <= '0;
      m_valid_q   <= 1'b0;
      s_valid_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      m_pay_q     <= m_pay_d;
      s_pay_q     <= s_pay_d;
      m_valid_q   <= m_valid_d;
      s_valid_q   <= s_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign {WB_out, loadout, dataout, Aluresout} = m_pay_q;
  assign out_valid = m_valid_q;
  assign stall_cnt = stall_cnt_q;
  assign wb_data   = WB_out[0] ? dataout : Aluresout;
  assign wb_we     = m_valid_q & WB_out[1] & ~((ZERO_GUARD != 0) && (loadout == '0));

endmodule

// File: tb/tb_mem_wb_skid.sv
// tb/tb_mem_wb_skid.sv - randomized bench for mem_wb_skid against a 2-deep FIFO model
module tb_mem_wb_skid;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  WB_in = '0;
  logic [4:0]  loadreg = '0;
  logic [31:0] readdata = '0;
  logic [31:0] Aluresult = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, wb_we;
  logic [1:0]  WB_out;
  logic [4:0]  loadout;
  logic [31:0] dataout, Aluresout, wb_data;
  logic [15:0] stall_cnt;

  logic        g_in_ready, g_out_valid, g_wb_we;
  logic [1:0]  g_WB_out;
  logic [4:0]  g_loadout;
  logic [31:0] g_dataout, g_Aluresout, g_wb_data;
  logic [2:0]  g_stall_cnt;

  always #5 clk = ~clk;

  mem_wb_skid #(.N(32), .REGW(5), .WBW(2), .ZERO_GUARD(1), .CNTW(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .WB_in(WB_in), .loadreg(loadreg), .readdata(readdata), .Aluresult(Aluresult),
    .out_valid(out_valid), .out_ready(out_ready), .WB_out(WB_out), .loadout(loadout),
    .dataout(dataout), .Aluresout(Aluresout), .wb_data(wb_data), .wb_we(wb_we),
    .stall_cnt(stall_cnt)
  );

  mem_wb_skid #(.N(32), .REGW(5), .WBW(2), .ZERO_GUARD(0), .CNTW(3)) u_g0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(g_in_ready),
    .WB_in(WB_in), .loadreg(loadreg), .readdata(readdata), .Aluresult(Aluresult),
    .out_valid(g_out_valid), .out_ready(out_ready), .WB_out(g_WB_out), .loadout(g_loadout),
    .dataout(g_dataout), .Aluresout(g_Aluresout), .wb_data(g_wb_data), .wb_we(g_wb_we),
    .stall_cnt(g_stall_cnt)
  );

  typedef struct packed {
    logic [1:0]  wb;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic [31:0] alu;
  } entry_t;

  entry_t mq[$];
  int     mcnt16 = 0;
  int     mcnt3  = 0;
  int     tests  = 0;
  int     fails  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: an ordered queue of at most two entries; ready whenever fewer than two are held.
  always @(negedge rst_n) begin
    mq.delete();
    mcnt16 = 0;
    mcnt3  = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      bit acc, con;
      acc = in_valid && (mq.size() < 2);
      con = (mq.size() > 0) && out_ready;
      if (mq.size() > 0 && !out_ready) begin
        if (mcnt16 < 65535) mcnt16++;
        if (mcnt3 < 7) mcnt3++;
      end
      if (flush) mq.delete();
      else begin
        if (con) void'(mq.pop_front());
        if (acc) mq.push_back({WB_in, loadreg, readdata, Aluresult});
      end
    end
  end

  always @(negedge clk) begin
    entry_t e;
    chk("out_valid", out_valid, mq.size() > 0);
    chk("in_ready", in_ready, mq.size() < 2);
    chk("stall_cnt", stall_cnt, mcnt16);
    chk("g0_out_valid", g_out_valid, mq.size() > 0);
    chk("g0_in_ready", g_in_ready, mq.size() < 2);
    chk("g0_stall_cnt", g_stall_cnt, mcnt3);
    if (mq.size() > 0) begin
      e = mq[0];
      chk("WB_out", WB_out, e.wb);
      chk("loadout", loadout, e.rd);
      chk("dataout", dataout, e.rdata);
      chk("Aluresout", Aluresout, e.alu);
      chk("wb_data", wb_data, e.wb[0] ? e.rdata : e.alu);
      chk("wb_we", wb_we, e.wb[1] && (e.rd != 0));
      chk("g0_wb_data", g_wb_data, e.wb[0] ? e.rdata : e.alu);
      chk("g0_wb_we", g_wb_we, e.wb[1]);
    end else begin
      chk("wb_we_idle", wb_we, 1'b0);
      chk("g0_wb_we_idle", g_wb_we, 1'b0);
    end
  end

  // Drive one cycle's inputs at a negedge and return at the next negedge.
  task automatic cyc(input logic v, input logic [1:0] wb, input logic [4:0] rd,
                     input logic [31:0] rdat, input logic [31:0] alu,
                     input logic ordy, input logic fl);
    in_valid = v; WB_in = wb; loadreg = rd; readdata = rdat; Aluresult = alu;
    out_ready = ordy; flush = fl;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_stall", stall_cnt, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      cyc(1, 2'b10, 5, 32'h0, 32'h10 + i, 1, 0);
      chk("stream_wb_data", wb_data, 32'h10 + i);
      chk("stream_wb_we", wb_we, 1);
      chk("stream_in_ready", in_ready, 1);
    end
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("stream_drained", out_valid, 0);

    cyc(1, 2'b11, 7, 32'hDEAD, 32'h1, 0, 0);
    chk("bp_A_data", wb_data, 32'hDEAD);
    chk("bp_A_stall", stall_cnt, 0);
    cyc(1, 2'b10, 8, 32'h0, 32'hB, 0, 0);
    chk("bp_B_skid_ready", in_ready, 0);
    chk("bp_B_stall", stall_cnt, 1);
    cyc(1, 2'b10, 9, 32'h0, 32'hC, 0, 0);
    chk("bp_C_held", in_ready, 0);
    chk("bp_C_stall", stall_cnt, 2);
    chk("bp_A_still", loadout, 7);
    cyc(1, 2'b10, 9, 32'h0, 32'hC, 1, 0);
    chk("bp_B_out", loadout, 8);
    chk("bp_B_wb_data", wb_data, 32'hB);
    chk("bp_ready_back", in_ready, 1);
    cyc(1, 2'b10, 9, 32'h0, 32'hC, 1, 0);
    chk("bp_C_out", loadout, 9);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("bp_drained", out_valid, 0);
    chk("bp_stall_final", stall_cnt, 2);

    cyc(1, 2'b10, 3, 32'h0, 32'hE, 0, 0);
    cyc(1, 2'b10, 4, 32'h0, 32'hF, 0, 0);
    chk("fl_skid_full", in_ready, 0);
    cyc(1, 2'b10, 6, 32'h0, 32'hD, 1, 1);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_stall", stall_cnt, 3);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("fl_D_gone", out_valid, 0);

    cyc(1, 2'b10, 0, 32'h0, 32'h55, 1, 0);
    chk("x0_valid", out_valid, 1);
    chk("x0_we_guard", wb_we, 0);
    chk("x0_we_noguard", g_wb_we, 1);
    cyc(0, 0, 0, 0, 0, 1, 0);

    cyc(1, 2'b11, 1, 32'h77, 32'h0, 0, 0);
    cyc(1, 2'b10, 2, 32'h0, 32'h88, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_stall", stall_cnt, 0);
    chk("arst_wb_data", wb_data, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_g0_stall", g_stall_cnt, 0);
    @(negedge clk);
    in_valid = 1'b1; WB_in = 2'b10; loadreg = 5; readdata = 0; Aluresult = 32'h10; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_data", wb_data, 32'h10);
    chk("post_rst_we", wb_we, 1);

    cyc(1, 2'b10, 5, 32'h0, 32'h11, 0, 0);
    for (int i = 0; i < 11; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("sat_g0_stall", g_stall_cnt, 7);
    chk("sat_main_stall", stall_cnt, 12);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      cyc($urandom_range(0, 9) < 7, 2'($urandom), rd, $urandom, $urandom,
          $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1, 0);
    chk("end_empty", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
